// File: rtl/memory_cycle_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: bus geometry defaults
// and the transfer-sequencing state encoding.
package memory_cycle_lsu_pkg;

  localparam int unsigned LSU_DATA_W = 256;
  localparam int unsigned LSU_BUS_W  = 32;
  localparam int unsigned LSU_ADDR_W = 32;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Width of a beat index; a single-beat bus still needs a 1-bit counter.
  function automatic int unsigned lsu_beat_idx_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/memory_cycle_lsu_beat_serializer.sv
// Beat sequencer for one vector access: beat counter, beat address,
// outgoing write slice and the load assembly buffer. Beat 0 is the LSW.
module lsu_beat_serializer
  import memory_cycle_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned BUS_W  = LSU_BUS_W,
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              beat_ack_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [DATA_W-1:0] wvec_i,
  input  logic [BUS_W-1:0]  rdata_i,
  output logic              last_beat_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BUS_W-1:0]  wdata_o,
  output logic [DATA_W-1:0] rbuf_o
);

  localparam int unsigned BEATS  = DATA_W / BUS_W;
  localparam int unsigned BEAT_W = lsu_beat_idx_w(BEATS);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BUS_W / 8);

  logic [BEAT_W-1:0] beat_q, beat_d, beat_nxt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d, wslice_nxt;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  assign last_beat_o = (beat_q == BEAT_W'(BEATS - 1));
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign rbuf_o      = rbuf_q;

  // Next beat: advance counter/address, pick next write slice, capture read beat.
  always_comb begin
    beat_d     = beat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    beat_nxt   = beat_q + BEAT_W'(1);
    wslice_nxt = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_nxt == BEAT_W'(k)) wslice_nxt = wvec_i[k*BUS_W +: BUS_W];
    end
    if (start_i) begin
      beat_d  = '0;
      addr_d  = base_i;
      wdata_d = wvec_i[BUS_W-1:0];
    end else if (beat_ack_i) begin
      if (fill_i) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (beat_q == BEAT_W'(k)) rbuf_d[k*BUS_W +: BUS_W] = rdata_i;
        end
      end
      // Address steps incrementally so it wraps modulo 2^ADDR_W for free.
      if (!last_beat_o) begin
        beat_d  = beat_nxt;
        addr_d  = addr_q + STRIDE;
        wdata_d = wslice_nxt;
      end
    end
  end

  // Beat state registers, updated with the pipeline on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst) begin
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
    end
  end

endmodule

// File: rtl/memory_cycle_lsu.sv
// MEM pipeline stage: MEM/WB register plus a serialiser that moves 256-bit
// vector loads/stores over a narrow req/ack bus while stalling upstream.
module memory_cycle_lsu
  import memory_cycle_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned BUS_W  = LSU_BUS_W,
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [4:0]        RdM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [4:0]        RdW,
  output logic [DATA_W-1:0] PCPlus4W
);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              rw_q, rw_d;
  logic              rs_q, rs_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;

  logic              mem_op, start, beat_ack, last_beat;
  logic [DATA_W-1:0] rbuf;

  assign mem_op   = MemWriteM | ResultSrcM;
  assign start    = (state_q == LSU_IDLE) && mem_op;
  // Acks outside BUSY never reach the serialiser.
  assign beat_ack = (state_q == LSU_BUSY) && mem_ack;
  assign StallM   = start || (state_q == LSU_BUSY);

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign RegWriteW  = rw_q;
  assign ResultSrcW = rs_q;
  assign ReadDataW  = rdat_q;
  assign ALUResultW = alu_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pc4_q;

  lsu_beat_serializer #(
    .DATA_W (DATA_W),
    .BUS_W  (BUS_W),
    .ADDR_W (ADDR_W)
  ) u_beats (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .beat_ack_i  (beat_ack),
    .fill_i      (~we_q),
    .base_i      (ALUResultM[ADDR_W-1:0]),
    .wvec_i      (WriteDataM),
    .rdata_i     (mem_rdata),
    .last_beat_o (last_beat),
    .addr_o      (mem_addr),
    .wdata_o     (mem_wdata),
    .rbuf_o      (rbuf)
  );

  // Sequencing FSM and MEM/WB next-state; stalled cycles write a bubble.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    rw_d    = rw_q;
    rs_d    = rs_q;
    rdat_d  = rdat_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    pc4_d   = pc4_q;
    case (state_q)
      LSU_IDLE: begin
        if (mem_op) begin
          state_d = LSU_BUSY;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          rw_d    = 1'b0;
          rs_d    = 1'b0;
        end else begin
          rw_d  = RegWriteM;
          rs_d  = ResultSrcM;
          alu_d = ALUResultM;
          rd_d  = RdM;
          pc4_d = PCPlus4M;
        end
      end
      LSU_BUSY: begin
        rw_d = 1'b0;
        rs_d = 1'b0;
        if (beat_ack && last_beat) begin
          state_d = LSU_DONE;
          req_d   = 1'b0;
        end
      end
      LSU_DONE: begin
        rw_d  = RegWriteM;
        rs_d  = ResultSrcM;
        alu_d = ALUResultM;
        rd_d  = RdM;
        pc4_d = PCPlus4M;
        // Stores (including store+load encodings) leave ReadDataW untouched.
        if (!we_q) rdat_d = rbuf;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and MEM/WB registers; reset abandons any partial transfer.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      rdat_q  <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      rdat_q  <= rdat_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      pc4_q   <= pc4_d;
    end
  end

endmodule

// File: tb/tb_memory_cycle_lsu.sv
// Scoreboard bench for memory_cycle_lsu: the driver pushes expected bus beats
// and MEM/WB retirements; monitors pop and compare as the DUT presents them.
module tb_memory_cycle_lsu;

  localparam int DW = 256;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int NB = DW / BW;

  typedef struct {
    logic          rw;
    logic          rs;
    logic [DW-1:0] alu;
    logic [4:0]    rd;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rdat;
  } wrec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] wdata;
  } beat_t;

  logic          clk, rst;
  logic          RegWriteM, ResultSrcM, MemWriteM;
  logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]    RdM;
  logic          StallM, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          RegWriteW, ResultSrcW;
  logic [DW-1:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]    RdW;

  wrec_t exp_w[$];
  beat_t exp_b[$];
  wrec_t last_w;
  logic [DW-1:0] model_rd;
  int n_cmp = 0;
  int n_fail = 0;
  int wait_cfg = 0;
  int wait_sum = 0;
  bit rd_mode = 0;

  memory_cycle_lsu #(
    .DATA_W (DW),
    .BUS_W  (BW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Memory contents seen by loads: a fixed function of the byte address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (rd_mode) return 32'hA0 + ((a - 32'h200) >> 2);
    return (a * 32'h9E3779B1) ^ 32'h0000_00C3;
  endfunction

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int pick_wait();
    if (wait_cfg < 0) return int'($urandom_range(0, 2));
    return wait_cfg;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Bus slave: per-beat wait states, spurious acks while no request is open.
  initial begin
    int wl;
    wl = -1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (!rst || !mem_req) begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        wl = -1;
      end else begin
        if (wl < 0) wl = pick_wait();
        if (wl > 0) begin
          wl--;
          wait_sum++;
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end else begin
          mem_ack = 1'b1;
          mem_rdata = rd_fn(mem_addr);
          wl = -1;
        end
      end
    end
  end

  // Monitor: each falling edge either resets, retires one instruction, or bubbles.
  initial begin
    logic s_prev, r_prev;
    bit have;
    wrec_t e;
    beat_t b;
    have = 0;
    s_prev = 1'b0;
    r_prev = 1'b0;
    forever begin
      @(posedge clk);
      if (have) begin
        if (!r_prev) begin
          chk("rst_RegWriteW", 256'(RegWriteW), '0);
          chk("rst_ResultSrcW", 256'(ResultSrcW), '0);
          chk("rst_ALUResultW", ALUResultW, '0);
          chk("rst_RdW", 256'(RdW), '0);
          chk("rst_PCPlus4W", PCPlus4W, '0);
          chk("rst_ReadDataW", ReadDataW, '0);
          chk("rst_mem_req", 256'(mem_req), '0);
          chk("rst_mem_we", 256'(mem_we), '0);
          chk("rst_mem_addr", 256'(mem_addr), '0);
          chk("rst_mem_wdata", 256'(mem_wdata), '0);
          last_w.rw = 0; last_w.rs = 0; last_w.alu = '0;
          last_w.rd = '0; last_w.pc4 = '0; last_w.rdat = '0;
        end else if (!s_prev) begin
          if (exp_w.size() == 0) begin
            chk("w_unexpected_retire", 256'(1), 256'(0));
          end else begin
            e = exp_w.pop_front();
            chk("RegWriteW", 256'(RegWriteW), 256'(e.rw));
            chk("ResultSrcW", 256'(ResultSrcW), 256'(e.rs));
            chk("ALUResultW", ALUResultW, e.alu);
            chk("RdW", 256'(RdW), 256'(e.rd));
            chk("PCPlus4W", PCPlus4W, e.pc4);
            chk("ReadDataW", ReadDataW, e.rdat);
            last_w = e;
          end
        end else begin
          chk("bubble_RegWriteW", 256'(RegWriteW), '0);
          chk("bubble_ResultSrcW", 256'(ResultSrcW), '0);
          chk("bubble_ALUResultW", ALUResultW, last_w.alu);
          chk("bubble_RdW", 256'(RdW), 256'(last_w.rd));
          chk("bubble_PCPlus4W", PCPlus4W, last_w.pc4);
          chk("bubble_ReadDataW", ReadDataW, last_w.rdat);
        end
      end
      #3;
      s_prev = StallM;
      r_prev = rst;
      have = 1;
      if (rst && mem_req && mem_ack) begin
        if (exp_b.size() == 0) begin
          chk("beat_unexpected", 256'(1), 256'(0));
        end else begin
          b = exp_b.pop_front();
          chk("beat_addr", 256'(mem_addr), 256'(b.addr));
          chk("beat_we", 256'(mem_we), 256'(b.we));
          chk("beat_wdata", 256'(mem_wdata), 256'(b.wdata));
        end
      end
    end
  end

  task automatic zero_inputs();
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
    ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0;
    zero_inputs();
    model_rd = '0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Present one instruction for as long as StallM holds it; abort_at>0
  // asserts reset at that stall cycle instead of letting it complete.
  task automatic issue(input logic rw, input logic rs, input logic mw,
                       input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                       input logic [DW-1:0] pc4, input logic [4:0] rd,
                       input int waits, input int abort_at);
    wrec_t e;
    beat_t b;
    logic [31:0] base;
    logic [DW-1:0] ld;
    int n, ws0;
    bit memop, stopped;
    @(posedge clk); #1;
    rst = 1'b1;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
    wait_cfg = waits;
    ws0 = wait_sum;
    memop = mw | rs;
    e.rw = rw; e.rs = rs; e.alu = alu; e.rd = rd; e.pc4 = pc4;
    if (memop) begin
      base = alu[31:0];
      for (int k = 0; k < NB; k++) begin
        b.addr = base + 32'(4 * k);
        b.we = mw;
        b.wdata = wd[k*32 +: 32];
        exp_b.push_back(b);
        ld[k*32 +: 32] = rd_fn(b.addr);
      end
      if (rs && !mw) model_rd = ld;
    end
    e.rdat = model_rd;
    exp_w.push_back(e);
    #1;
    n = 0;
    stopped = 0;
    while (StallM === 1'b1) begin
      n++;
      if (n == abort_at || n > 400) begin
        if (n > 400) begin
          n_cmp++; n_fail++;
          $display("FAIL stall_timeout: got %0d stall cycles, required release", n);
        end
        rst = 1'b0;
        zero_inputs();
        if (exp_w.size() > 0) exp_w.delete(exp_w.size() - 1);
        exp_b.delete();
        model_rd = '0;
        stopped = 1;
        break;
      end
      @(posedge clk); #2;
    end
    if (!stopped) chk("stall_cycles", 256'(n), memop ? 256'(1 + NB + (wait_sum - ws0)) : '0);
  endtask

  initial begin
    logic [DW-1:0] a, wd;
    int kind;
    rst = 1'b0;
    zero_inputs();
    model_rd = '0;
    do_reset(3);

    issue(1, 0, 0, 256'h1234, rand256(), 256'h44, 5'd5, 0, 0);

    for (int k = 0; k < NB; k++) wd[k*32 +: 32] = 32'(k + 1);
    issue(1, 0, 1, 256'h100, wd, 256'h48, 5'd6, 0, 0);

    rd_mode = 1;
    issue(1, 1, 0, 256'h200, rand256(), 256'h4C, 5'd7, 2, 0);
    rd_mode = 0;

    a = rand256();
    a[31:0] = 32'hFFFF_FFF8;
    issue(1, 1, 0, a, rand256(), rand256(), 5'd8, -1, 0);

    a = rand256();
    a[31:0] = 32'h0000_0400;
    issue(0, 0, 1, a, rand256(), rand256(), 5'd9, 0, 6);
    @(posedge clk); #2;
    chk("post_reset_StallM", 256'(StallM), '0);
    chk("post_reset_mem_req", 256'(mem_req), '0);
    issue(1, 0, 0, rand256(), rand256(), rand256(), 5'd10, 0, 0);

    issue(1, 1, 0, 256'h300, rand256(), rand256(), 5'd11, -1, 0);
    issue(1, 0, 0, rand256(), rand256(), rand256(), 5'd12, 0, 0);
    issue(1, 1, 1, 256'h500, rand256(), rand256(), 5'd13, -1, 0);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 2: issue(1'($urandom), 0, 0, rand256(), rand256(), rand256(), 5'($urandom), -1, 0);
        3:       issue(1'($urandom), 1, 0, rand256(), rand256(), rand256(), 5'($urandom), -1, 0);
        4:       issue(1'($urandom), 0, 1, rand256(), rand256(), rand256(), 5'($urandom), -1, 0);
        default: issue(1'($urandom), 1, 1, rand256(), rand256(), rand256(), 5'($urandom), -1, 0);
      endcase
    end

    @(posedge clk); #4;
    chk("w_queue_drained", 256'(exp_w.size()), '0);
    chk("beat_queue_drained", 256'(exp_b.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
